jk_drive_sequencer: RTL and testbench
=====================================

JK_DRIVE_SEQUENCER -- requirements
Module: jk_drive_sequencer

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 4, width of the drive-count field and internal down-counter.
REQ-002 The block SHALL have one clock and synchronous, active-low reset, with ports:
- Ck  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-low reset
REQ-003 The block SHALL have the following command-handshake ports:
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  operation: 00 hold, 01 clear (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1)
- cmd_count  in  CNT_W  number of drive cycles; 0 means 2^CNT_W
REQ-004 The block SHALL have the following ports toward the downstream JK flip-flop:
- J  out  1  J drive
- K  out  1  K drive
- Q_fb  in  1  Q output fed back from the flip-flop
REQ-005 The block SHALL have the following status ports:
- busy  out  1  high in DRIVE and CHECK
- done  out  1  one-cycle pulse at command completion
- mismatch  out  1  sticky error flag
- clr_err  in  1  clears mismatch

Function
REQ-006 The block SHALL implement the FSM states IDLE, DRIVE and CHECK.
REQ-007 In IDLE, the block SHALL hold cmd_ready=1, J=0, K=0 and busy=0; cmd_ready SHALL be 0 in DRIVE and CHECK.
REQ-008 A command SHALL be accepted on the rising edge where cmd_valid=1 and cmd_ready=1, and the FSM SHALL move to DRIVE on that edge.
REQ-009 On acceptance, the block SHALL latch cmd_op and cmd_count, and SHALL load the down-counter with cmd_count (0 loads 2^CNT_W).
REQ-010 On acceptance, the block SHALL latch the expected final Q as follows:
- hold: Q_fb
- clear: 0
- set: 1
- toggle: Q_fb XOR (parity of the effective count)
REQ-011 In DRIVE, J and K SHALL be driven from their own registers per the latched op for exactly N consecutive cycles, where N is the effective count, so that the flip-flop samples exactly N rising edges with that J/K pair.
REQ-012 In DRIVE, the counter SHALL decrement each cycle; on the edge that ends the cycle where the counter equals 1, the FSM SHALL move to CHECK.
REQ-013 In CHECK (one cycle), the block SHALL:
- drive J=0, K=0
- pulse done=1
- compare Q_fb with the latched expected value
- return to IDLE on the next edge
REQ-014 A compare difference in CHECK SHALL set mismatch=1 on the next edge, and mismatch SHALL stay 1 until clr_err or reset.
REQ-015 clr_err=1 SHALL clear mismatch on the next edge; if a new mismatch is detected in the same cycle, mismatch SHALL be 1 (set wins).
REQ-016 Latency from acceptance edge to done pulse SHALL be N+1 cycles; minimum command spacing SHALL be N+2 cycles (no acceptance in CHECK).
REQ-017 cmd_valid, cmd_op and cmd_count SHALL be ignored while cmd_ready=0; a held cmd_valid SHALL be accepted on the first IDLE cycle.
REQ-018 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-019 Reset=0 sampled at a rising edge SHALL force the following on that edge, from any state including mid-DRIVE: FSM=IDLE, J=0, K=0, done=0, busy=0, mismatch=0, counter=0, cmd_ready=1.
REQ-020 Reset SHALL take priority over cmd_valid, clr_err and compare results, and no command SHALL be accepted while Reset=0.

Verification
REQ-021 The bench SHALL cover a set command: Q_fb model starts 0, op=10, count=3 -> J=1/K=0 for exactly 3 cycles, done at acceptance+4, mismatch=0, final Q=1.
REQ-022 The bench SHALL cover a toggle command against both a correct JK model and a Q_fb stuck at 0: op=11, count=5, Q start 0 -> correct model: expected 1, mismatch=0; stuck model: mismatch=1, still 1 after a following clean command.
REQ-023 The bench SHALL cover count wrap-around: op=01, count=0, CNT_W=4 -> J=0/K=1 for exactly 16 cycles, done at acceptance+17.
REQ-024 The bench SHALL cover reset mid-operation: Reset=0 on the 2nd DRIVE cycle of a count=8 command -> next edge J=0, K=0, busy=0, cmd_ready=1, mismatch=0, no done pulse.
REQ-025 The bench SHALL cover handshake back-pressure: cmd_valid held high with count=2 -> second command accepted exactly 4 cycles after the first.
REQ-026 The bench SHALL cover clear/set collision: clr_err=1 in the same cycle as a CHECK mismatch -> mismatch=1; clr_err=1 alone later -> mismatch=0 next edge.

Source files
------------

// File: rtl/jk_drive_sequencer.sv
// Drives a downstream JK flip-flop with a J/K pair for a commanded number of
// cycles, then checks the fed-back Q against the value that command should produce.
module jk_drive_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             Ck,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             J,
    output logic             K,
    input  logic             Q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    input  logic             clr_err,
    output logic [1:0]       fsm_state
);

    // Handshake: a command transfers on the rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is 1 only in IDLE, and the command
    // inputs are don't-care whenever cmd_ready is 0.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

    state_t         state;
    state_t         state_nxt;
    logic [CNT_W:0] cnt;
    logic           exp_q;
    logic           accept;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == CHECK);
    assign fsm_state = state;

    always_ff @(posedge Ck) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   if (cnt == CNT_ONE) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Ck) begin
        if (!Reset) begin
            J        <= 1'b0;
            K        <= 1'b0;
            cnt      <= '0;
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            // A fresh compare failure outranks a simultaneous clear request.
            if (state == CHECK && Q_fb != exp_q) begin
                mismatch <= 1'b1;
            end else if (clr_err) begin
                mismatch <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        J   <= cmd_op[1];
                        K   <= cmd_op[0];
                        cnt <= (cmd_count == '0) ? CNT_FULL : {1'b0, cmd_count};
                        // A zero count means 2^CNT_W (even), so bit 0 is the parity in every case.
                        case (cmd_op)
                            2'b00:   exp_q <= Q_fb;
                            2'b01:   exp_q <= 1'b0;
                            2'b10:   exp_q <= 1'b1;
                            default: exp_q <= Q_fb ^ cmd_count[0];
                        endcase
                    end
                end
                DRIVE: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        J <= 1'b0;
                        K <= 1'b0;
                    end
                end
                default: begin
                    J <= 1'b0;
                    K <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer: a JK flip-flop model closes the loop, a
// cycle-indexed transaction model predicts every output, directed cases pin literals.
module tb_jk_drive_sequencer;

    localparam int CNT_W = 4;
    localparam int FULL  = 1 << CNT_W;

    logic             Ck = 1'b0;
    logic             Reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             J, K;
    logic             Q_fb;
    logic             busy, done, mismatch;
    logic             clr_err = 1'b0;
    logic [1:0]       fsm_state;

    logic ff_q = 1'b0;
    logic ff_clr = 1'b0;
    logic stuck = 1'b0;

    int tests = 0;
    int fails = 0;

    jk_drive_sequencer #(.CNT_W(CNT_W)) dut (
        .Ck(Ck), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .J(J), .K(K), .Q_fb(Q_fb),
        .busy(busy), .done(done), .mismatch(mismatch), .clr_err(clr_err),
        .fsm_state(fsm_state)
    );

    always #5 Ck = ~Ck;

    // Downstream flip-flop; the stuck switch models a broken feedback path.
    always @(posedge Ck) begin
        if (ff_clr) ff_q <= 1'b0;
        else begin
            case ({J, K})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign Q_fb = stuck ? 1'b0 : ff_q;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle time %0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: each accepted command books a window of cycles.
    int cyc = 0;
    int free_at = 0;
    int drive_from = 0;
    int drive_to = -1;
    int check_at = -1;
    bit m_j = 0, m_k = 0, m_exp = 0, m_mm = 0;
    bit started = 0;

    always @(posedge Ck) begin
        int n;
        if (!Reset) begin
            free_at  = cyc + 1;
            drive_to = -1;
            check_at = -1;
            m_mm     = 0;
        end else begin
            if (cyc == check_at && Q_fb != m_exp) m_mm = 1;
            else if (clr_err) m_mm = 0;
            if (cmd_valid && cyc >= free_at) begin
                n = (cmd_count == 0) ? FULL : int'(cmd_count);
                drive_from = cyc + 1;
                drive_to   = cyc + n;
                check_at   = cyc + n + 1;
                free_at    = cyc + n + 2;
                case (cmd_op)
                    2'b00: begin m_j = 0; m_k = 0; m_exp = Q_fb; end
                    2'b01: begin m_j = 0; m_k = 1; m_exp = 0; end
                    2'b10: begin m_j = 1; m_k = 0; m_exp = 1; end
                    default: begin m_j = 1; m_k = 1; m_exp = Q_fb ^ n[0]; end
                endcase
            end
        end
        cyc++;
        started = 1;
    end

    always @(negedge Ck) begin
        bit in_drive;
        if (started) begin
            in_drive = (cyc >= drive_from) && (cyc <= drive_to);
            chk("cmd_ready", int'(cmd_ready), int'(cyc >= free_at));
            chk("busy", int'(busy), int'(cyc < free_at));
            chk("J", int'(J), in_drive ? int'(m_j) : 0);
            chk("K", int'(K), in_drive ? int'(m_k) : 0);
            chk("done", int'(done), int'(cyc == check_at));
            chk("mismatch", int'(mismatch), int'(m_mm));
        end
    end

    task automatic clear_ff();
        @(negedge Ck) ff_clr = 1'b1;
        @(negedge Ck) ff_clr = 1'b0;
    endtask

    // Presents a command and returns right after the accepting edge.
    task automatic accept_cmd(input logic [1:0] op, input int count);
        bit ok;
        ok = 0;
        @(negedge Ck);
        cmd_op = op;
        cmd_count = CNT_W'(count);
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge Ck);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge Ck);
    endtask

    // Watches cycles after acceptance until done; lat is cycles from acceptance edge.
    task automatic watch(input logic [1:0] op, input bit clr_at_done,
                         output int pulses, output int lat);
        pulses = 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Ck);
            if (i == 1) cmd_valid = 1'b0;
            if (busy && {J, K} == op) pulses++;
            if (done) begin
                lat = i;
                if (clr_at_done) clr_err = 1'b1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int pulses, lat, first, second, seen;

        // Reset
        repeat (3) @(negedge Ck);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_jk", int'({J, K}), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        Reset = 1'b1;
        clear_ff();

        // Set, count 3
        accept_cmd(2'b10, 3);
        watch(2'b10, 0, pulses, lat);
        chk("set_pulses", pulses, 3);
        chk("set_latency", lat, 4);
        chk("set_final_q", int'(ff_q), 1);
        chk("set_mismatch", int'(mismatch), 0);

        // Toggle, count 5, healthy feedback
        clear_ff();
        accept_cmd(2'b11, 5);
        watch(2'b11, 0, pulses, lat);
        chk("tog_pulses", pulses, 5);
        chk("tog_latency", lat, 6);
        chk("tog_final_q", int'(ff_q), 1);
        @(negedge Ck);
        chk("tog_mismatch", int'(mismatch), 0);

        // Toggle, count 5, feedback stuck at 0
        stuck = 1'b1;
        clear_ff();
        accept_cmd(2'b11, 5);
        watch(2'b11, 0, pulses, lat);
        @(negedge Ck);
        chk("stuck_mismatch", int'(mismatch), 1);
        stuck = 1'b0;
        accept_cmd(2'b10, 2);
        watch(2'b10, 0, pulses, lat);
        @(negedge Ck);
        chk("sticky_mismatch", int'(mismatch), 1);

        // Clear with count 0 wraps to 16
        accept_cmd(2'b01, 0);
        watch(2'b01, 0, pulses, lat);
        chk("wrap_pulses", pulses, FULL);
        chk("wrap_latency", lat, FULL + 1);
        chk("wrap_final_q", int'(ff_q), 0);

        // Reset in the second DRIVE cycle of a count-8 command
        accept_cmd(2'b10, 8);
        @(negedge Ck) cmd_valid = 1'b0;
        @(negedge Ck) Reset = 1'b0;
        @(negedge Ck) Reset = 1'b1;
        chk("mid_rst_jk", int'({J, K}), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_mismatch", int'(mismatch), 0);
        seen = int'(done);
        repeat (12) begin
            @(negedge Ck);
            if (done) seen = 1;
        end
        chk("mid_rst_no_done", seen, 0);

        // Back-pressure: cmd_valid held high with count 2
        cmd_op = 2'b10;
        cmd_count = CNT_W'(2);
        cmd_valid = 1'b1;
        first = -1;
        second = -1;
        for (int i = 0; i < 30; i++) begin
            if (cmd_ready) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            if (second >= 0) break;
            @(negedge Ck);
        end
        chk("backpressure_gap", second - first, 4);
        @(negedge Ck) cmd_valid = 1'b0;
        repeat (6) @(negedge Ck);

        // clr_err colliding with a CHECK mismatch, then clr_err alone
        stuck = 1'b1;
        clear_ff();
        accept_cmd(2'b10, 1);
        watch(2'b10, 1, pulses, lat);
        @(negedge Ck);
        clr_err = 1'b0;
        chk("collision_mismatch", int'(mismatch), 1);
        stuck = 1'b0;
        clr_err = 1'b1;
        @(negedge Ck);
        clr_err = 1'b0;
        chk("clr_mismatch", int'(mismatch), 0);

        // Randomized traffic checked by the model on every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge Ck);
            Reset = ($urandom_range(0, 49) != 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op = 2'($urandom_range(0, 3));
            cmd_count = CNT_W'($urandom_range(0, FULL - 1));
            clr_err = ($urandom_range(0, 19) == 0);
            if (i % 200 == 0) stuck = ($urandom_range(0, 2) == 0);
        end
        @(negedge Ck);
        Reset = 1'b1;
        cmd_valid = 1'b0;
        clr_err = 1'b0;
        repeat (20) @(negedge Ck);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
